// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC register, req/ack instruction-memory port, IF/ID presentation.
// Optional: define IF_MISALIGN_TRAP_EN to trap misaligned redirect targets instead of aligning them.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
`ifdef IF_MISALIGN_TRAP_EN
  ,
  output logic        if_misalign
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN, S_PRESENT} state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redir_q, redir_d;
  logic [31:0] addr_q;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        if_valid_q, if_valid_d;
  logic        mis_q, mis_d;

  logic [31:0] tgt;
  logic        tgt_bad, redir_bad, pc_bad;
  logic        trap;
  logic [31:0] trap_addr;

`ifdef IF_MISALIGN_TRAP_EN
  assign tgt       = branch_target_i;
  assign tgt_bad   = |branch_target_i[1:0];
  assign redir_bad = |redir_q[1:0];
  assign pc_bad    = |pc_q[1:0];
  assign if_misalign = mis_q;
`else
  assign tgt       = branch_target_i & ~32'd3;
  assign tgt_bad   = 1'b0;
  assign redir_bad = 1'b0;
  assign pc_bad    = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redir_d    = redir_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    if_valid_d = if_valid_q;
    mis_d      = mis_q;
    trap       = 1'b0;
    trap_addr  = pc_q;
    unique case (state_q)
      S_IDLE: begin
        if (branch_flag_i) begin
          pc_d    = tgt;
          state_d = S_REQ;
          trap      = tgt_bad;
          trap_addr = tgt;
        end else if (!pc_bad) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (branch_flag_i && mem_ack_i) begin
          pc_d      = tgt;
          trap      = tgt_bad;
          trap_addr = tgt;
        end else if (branch_flag_i) begin
          // Request cannot be retracted: park the target until the ack lands.
          redir_d = tgt;
          state_d = S_DRAIN;
        end else if (mem_ack_i) begin
          if_pc_d    = pc_q;
          if_inst_d  = mem_rdata_i;
          if_valid_d = 1'b1;
          pc_d       = pc_q + 32'd4;
          state_d    = S_PRESENT;
        end
      end
      S_DRAIN: begin
        if (mem_ack_i) begin
          state_d = S_REQ;
          if (branch_flag_i) begin
            pc_d      = tgt;
            trap      = tgt_bad;
            trap_addr = tgt;
          end else begin
            pc_d      = redir_q;
            trap      = redir_bad;
            trap_addr = redir_q;
          end
        end else if (branch_flag_i) begin
          redir_d = tgt;
        end
      end
      S_PRESENT: begin
        if (branch_flag_i) begin
          if_valid_d = 1'b0;
          mis_d      = 1'b0;
          pc_d       = tgt;
          state_d    = S_REQ;
          trap       = tgt_bad;
          trap_addr  = tgt;
        end else if (!stall_i) begin
          if_valid_d = 1'b0;
          mis_d      = 1'b0;
          state_d    = mis_q ? S_IDLE : S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A misaligned redirect is presented as a NOP instead of being fetched.
    if (trap) begin
      state_d    = S_PRESENT;
      pc_d       = trap_addr;
      if_pc_d    = trap_addr;
      if_inst_d  = NOP;
      if_valid_d = 1'b1;
      mis_d      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      redir_q    <= '0;
      addr_q     <= '0;
      if_pc_q    <= '0;
      if_inst_q  <= '0;
      if_valid_q <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redir_q    <= redir_d;
      addr_q     <= pc_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      if_valid_q <= if_valid_d;
      mis_q      <= mis_d;
    end
  end

  assign mem_req_o  = (state_q == S_REQ) || (state_q == S_DRAIN);
  assign mem_addr_o = addr_q;
  assign if_pc      = if_pc_q;
  assign if_inst    = if_inst_q;
  assign if_valid   = if_valid_q;

endmodule
